// File: rtl/store_write_buffer.sv
// Store write buffer: queues execute-stage stores, drains them to data
// memory over valid/ack, and forwards the newest pending data to loads.
module store_write_buffer #(
  parameter int Data_Width = 32,
  parameter int Addr_Width = 32,
  parameter int Depth      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       StoreEn,
  input  logic [Addr_Width-1:0]      StoreAddr,
  input  logic [Data_Width-1:0]      StoreData,
  output logic                       StoreReady,
  output logic                       MemWriteEn,
  output logic [Addr_Width-1:0]      MemAddr,
  output logic [Data_Width-1:0]      MemWriteData,
  input  logic                       MemAck,
  input  logic [Addr_Width-1:0]      LoadAddr,
  output logic                       ForwardHit,
  output logic [Data_Width-1:0]      ForwardData,
  output logic                       Empty,
  output logic [$clog2(Depth):0]     Count
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;

  logic [Addr_Width-1:0] addr_q [Depth];
  logic [Data_Width-1:0] data_q [Depth];
  logic [Depth-1:0]      valid_q, valid_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic enq, deq;

  assign StoreReady = (count_q < CW'(Depth));
  assign Empty      = (count_q == '0);
  assign Count      = count_q;
  assign MemWriteEn = !Empty;

  assign enq = StoreEn && StoreReady;
  assign deq = MemWriteEn && MemAck;

  // Head entry presented to memory; zero when nothing is pending.
  always_comb begin
    MemAddr      = '0;
    MemWriteData = '0;
    if (!Empty) begin
      MemAddr      = addr_q[rptr_q];
      MemWriteData = data_q[rptr_q];
    end
  end

  // Pointer, count and valid-bit next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    if (deq) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + 1'b1;
    end
    if (enq) begin
      valid_d[wptr_q] = 1'b1;
      wptr_d          = wptr_q + 1'b1;
    end
    unique case (1'b1)
      (enq && !deq): count_d = count_q + 1'b1;
      (deq && !enq): count_d = count_q - 1'b1;
      default:       count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload; contents are qualified by valid_q so no reset needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wptr_q] <= StoreAddr;
      data_q[wptr_q] <= StoreData;
    end
  end

  // Oldest-to-youngest scan so the youngest match overwrites older ones.
  always_comb begin
    ForwardHit  = 1'b0;
    ForwardData = '0;
    for (int k = Depth; k >= 1; k--) begin
      logic [PW-1:0] idx;
      idx = wptr_q - PW'(k);
      if (valid_q[idx] && (addr_q[idx] == LoadAddr)) begin
        ForwardHit  = 1'b1;
        ForwardData = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: a model queue tracks accepted stores and
// a monitor checks every memory write and the occupancy each cycle.
module tb_store_write_buffer;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          StoreEn = 1'b0;
  logic [AW-1:0] StoreAddr = '0;
  logic [DW-1:0] StoreData = '0;
  logic          StoreReady;
  logic          MemWriteEn;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWriteData;
  logic          MemAck = 1'b0;
  logic [AW-1:0] LoadAddr = '0;
  logic          ForwardHit;
  logic [DW-1:0] ForwardData;
  logic          Empty;
  logic [2:0]    Count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];
  int          mcnt = 0;

  store_write_buffer #(.Data_Width(DW), .Addr_Width(AW), .Depth(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .StoreEn(StoreEn), .StoreAddr(StoreAddr), .StoreData(StoreData),
    .StoreReady(StoreReady),
    .MemWriteEn(MemWriteEn), .MemAddr(MemAddr),
    .MemWriteData(MemWriteData), .MemAck(MemAck),
    .LoadAddr(LoadAddr), .ForwardHit(ForwardHit),
    .ForwardData(ForwardData), .Empty(Empty), .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Async reset discards everything the model holds.
  always @(negedge rst_n) begin
    exp_q.delete();
    mcnt = 0;
  end

  // Monitor: checks head/occupancy, then applies the edge that follows.
  always @(negedge clk) begin
    if (rst_n) begin
      logic e, q;
      chk("mon_count", 64'(Count), 64'(mcnt));
      chk("mon_wen", 64'(MemWriteEn), 64'(mcnt != 0));
      if (MemWriteEn) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_stale got %0h want none", MemAddr);
        end else begin
          chk("mon_head", {MemAddr, MemWriteData}, exp_q[0]);
        end
      end
      q = (mcnt > 0) && MemAck;
      e = StoreEn && (mcnt < D);
      if (q && exp_q.size() > 0) void'(exp_q.pop_front());
      if (e) exp_q.push_back({StoreAddr, StoreData});
      mcnt = mcnt + int'(e) - int'(q);
    end
  end

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    StoreEn   = 1'b1;
    StoreAddr = a;
    StoreData = d;
    step();
    StoreEn = 1'b0;
  endtask

  task automatic drain(input int n);
    MemAck = 1'b1;
    repeat (n) step();
    MemAck = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_empty", 64'(Empty), 64'd1);
    chk("rst_ready", 64'(StoreReady), 64'd1);
    chk("rst_wen", 64'(MemWriteEn), 64'd0);
    chk("rst_hit", 64'(ForwardHit), 64'd0);
    chk("rst_count", 64'(Count), 64'd0);
    rst_n = 1'b1;
    step();

    // single store, held then acked
    LoadAddr  = 32'h10;
    StoreEn   = 1'b1;
    StoreAddr = 32'h10;
    StoreData = 32'hDEAD_BEEF;
    #1;
    chk("same_cyc_hit", 64'(ForwardHit), 64'd0);
    step();
    StoreEn = 1'b0;
    chk("one_wen", 64'(MemWriteEn), 64'd1);
    chk("one_addr", 64'(MemAddr), 64'h10);
    chk("one_data", 64'(MemWriteData), 64'hDEAD_BEEF);
    chk("one_count", 64'(Count), 64'd1);
    chk("one_hit", 64'(ForwardHit), 64'd1);
    chk("one_fwd", 64'(ForwardData), 64'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_addr", 64'(MemAddr), 64'h10);
      chk("hold_data", 64'(MemWriteData), 64'hDEAD_BEEF);
    end
    chk("acked_fwd", 64'(ForwardHit), 64'd1);
    drain(1);
    chk("one_empty", 64'(Empty), 64'd1);
    chk("one_mem0", 64'(MemAddr), 64'h0);

    // fill and stall
    for (int i = 0; i < 4; i++) store(32'(i * 4), 32'(i));
    chk("full_count", 64'(Count), 64'd4);
    chk("full_ready", 64'(StoreReady), 64'd0);
    store(32'h10, 32'h4);
    chk("drop_count", 64'(Count), 64'd4);
    MemAck = 1'b1;
    StoreEn = 1'b1;
    StoreAddr = 32'h50;
    StoreData = 32'h5;
    #1;
    chk("full_deq_ready", 64'(StoreReady), 64'd0);
    step();
    StoreEn = 1'b0;
    drain(3);
    chk("fill_empty", 64'(Empty), 64'd1);

    // forward priority
    store(32'h20, 32'hAAAA);
    store(32'h20, 32'hBBBB);
    LoadAddr = 32'h20;
    #1;
    chk("fwd_hit", 64'(ForwardHit), 64'd1);
    chk("fwd_young", 64'(ForwardData), 64'hBBBB);
    LoadAddr = 32'h24;
    #1;
    chk("fwd_miss", 64'(ForwardHit), 64'd0);
    chk("fwd_zero", 64'(ForwardData), 64'd0);
    LoadAddr  = 32'h30;
    StoreEn   = 1'b1;
    StoreAddr = 32'h30;
    StoreData = 32'hCCCC;
    #1;
    chk("fwd_enq_hidden", 64'(ForwardHit), 64'd0);
    step();
    StoreEn = 1'b0;
    chk("fwd_next_hit", 64'(ForwardHit), 64'd1);
    chk("fwd_next_data", 64'(ForwardData), 64'hCCCC);
    drain(3);
    chk("fwd_empty", 64'(Empty), 64'd1);

    // simultaneous enqueue/dequeue with wrap
    store(32'h100, 32'h100);
    store(32'h104, 32'h101);
    MemAck  = 1'b1;
    StoreEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      StoreAddr = 32'h200 + 32'(i * 4);
      StoreData = 32'h200 + 32'(i);
      step();
      chk("ss_count", 64'(Count), 64'd2);
    end
    StoreEn = 1'b0;
    LoadAddr = 32'h224;
    #1;
    chk("ss_fwd", 64'(ForwardData), 64'h209);
    drain(2);
    chk("ss_empty", 64'(Empty), 64'd1);

    // reset mid-operation
    store(32'h40, 32'h1);
    store(32'h44, 32'h2);
    store(32'h48, 32'h3);
    LoadAddr = 32'h44;
    #1;
    chk("pre_rst_count", 64'(Count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", 64'(MemWriteEn), 64'd0);
    chk("mid_rst_count", 64'(Count), 64'd0);
    chk("mid_rst_hit", 64'(ForwardHit), 64'd0);
    #1;
    rst_n = 1'b1;
    drain(4);
    chk("post_rst_empty", 64'(Empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
